// File: rtl/svm_wt_arbiter.sv
// svm_wt_arbiter: shares the single-port SVM weight RAM between host weight-load
// writes and fixed-length read bursts requested by PE groups. Writes win at each
// arbitration point; reads are served round-robin. All outputs are registered;
// rsp_data is the RAM's own output register, gated by the registered rsp_valid.
module svm_wt_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 6,
    parameter int WT_W      = 16,
    parameter int MAX_ADDR  = 35,
    parameter int BURST_LEN = 36,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_req,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WT_W-1:0]           wr_data,
    output logic                      wr_ack,
    output logic                      wr_err,
    input  logic [NUM_REQ-1:0]        rd_req,
    input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
    output logic [NUM_REQ-1:0]        rd_gnt,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [WT_W-1:0]           ram_wdata,
    input  logic [WT_W-1:0]           ram_rdata,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [WT_W-1:0]           rsp_data,
    output logic                      rsp_last,
    output logic                      busy
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_BURST} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [WT_W-1:0]     ram_wdata_q, ram_wdata_d;
    logic                wr_ack_q, wr_ack_d;
    logic                wr_err_q, wr_err_d;
    logic [NUM_REQ-1:0]  rd_gnt_q, rd_gnt_d;
    logic                rd_last_q, rd_last_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_last_q, rsp_last_d;
    logic                busy_q, busy_d;

    logic                rr_found;
    logic [ID_W-1:0]     rr_pick;
    logic [ADDR_W-1:0]   rd_start_raw;
    logic [ADDR_W-1:0]   rd_start;
    logic [ADDR_W-1:0]   addr_inc;

    // Round-robin search: first pending requester after the one served last.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!rr_found && rd_req[(int'(rr_q) + i) % NUM_REQ]) begin
                rr_found = 1'b1;
                rr_pick  = ID_W'((int'(rr_q) + i) % NUM_REQ);
            end
        end
    end

    assign rd_start_raw = rd_addr[int'(rr_pick) * ADDR_W +: ADDR_W];
    assign rd_start     = (rd_start_raw > ADDR_W'(MAX_ADDR)) ? '0 : rd_start_raw;
    assign addr_inc     = (ram_addr_q == ADDR_W'(MAX_ADDR)) ? '0 : ram_addr_q + ADDR_W'(1);

    // Next state and next registered RAM/handshake outputs.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        wr_ack_d    = 1'b0;
        wr_err_d    = 1'b0;
        rd_gnt_d    = '0;
        rd_last_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    state_d  = ST_WRITE;
                    wr_ack_d = 1'b1;
                    if (wr_addr > ADDR_W'(MAX_ADDR)) begin
                        wr_err_d = 1'b1;
                    end else begin
                        ram_en_d    = 1'b1;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = wr_addr;
                        ram_wdata_d = wr_data;
                    end
                end else if (rr_found) begin
                    state_d    = ST_BURST;
                    rr_d       = rr_pick;
                    id_d       = rr_pick;
                    rd_gnt_d   = NUM_REQ'(1) << rr_pick;
                    ram_en_d   = 1'b1;
                    ram_addr_d = rd_start;
                    cnt_d      = CNT_W'(1);
                    rd_last_d  = (BURST_LEN == 1);
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_BURST: begin
                if (cnt_q == CNT_W'(BURST_LEN)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = addr_inc;
                    cnt_d      = cnt_q + CNT_W'(1);
                    rd_last_d  = (cnt_q == CNT_W'(BURST_LEN - 1));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response tags trail the read enable by one cycle, matching RAM latency.
    always_comb begin
        rsp_valid_d = ram_en_q & ~ram_we_q;
        rsp_id_d    = id_q;
        rsp_last_d  = rd_last_q;
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any burst and its responses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_gnt_q    <= '0;
            rd_last_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            rd_gnt_q    <= rd_gnt_d;
            rd_last_q   <= rd_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_last_q  <= rsp_last_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign wr_err    = wr_err_q;
    assign rd_gnt    = rd_gnt_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_valid_q ? ram_rdata : '0;
    assign rsp_last  = rsp_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_svm_wt_arbiter.sv
// tb_svm_wt_arbiter: drives directed tables, multi-cycle corner sequences and
// random traffic; a transaction-level timeline model predicts every output cycle.
module tb_svm_wt_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 6;
    localparam int WT_W      = 16;
    localparam int MAX_ADDR  = 35;
    localparam int BURST_LEN = 36;
    localparam int ID_W      = 2;
    localparam int TLEN      = 8000;

    logic                      clk;
    logic                      rst;
    logic                      wr_req;
    logic [ADDR_W-1:0]         wr_addr;
    logic [WT_W-1:0]           wr_data;
    logic                      wr_ack;
    logic                      wr_err;
    logic [NUM_REQ-1:0]        rd_req;
    logic [NUM_REQ*ADDR_W-1:0] rd_addr;
    logic [NUM_REQ-1:0]        rd_gnt;
    logic                      ram_en;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [WT_W-1:0]           ram_wdata;
    logic [WT_W-1:0]           ram_rdata;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [WT_W-1:0]           rsp_data;
    logic                      rsp_last;
    logic                      busy;

    svm_wt_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .WT_W(WT_W),
        .MAX_ADDR(MAX_ADDR), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight RAM attached to the DUT: one-cycle read latency.
    logic [WT_W-1:0] ram_mem [0:63];
    logic [WT_W-1:0] shadow  [0:63];

    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Expected outputs for one cycle of the timeline.
    typedef struct packed {
        logic               ram_en;
        logic               ram_we;
        logic [ADDR_W-1:0]  ram_addr;
        logic [WT_W-1:0]    ram_wdata;
        logic               wr_ack;
        logic               wr_err;
        logic [NUM_REQ-1:0] rd_gnt;
        logic               rsp_valid;
        logic [ID_W-1:0]    rsp_id;
        logic [WT_W-1:0]    rsp_data;
        logic               rsp_last;
        logic               busy;
    } exp_t;

    exp_t tl [0:TLEN-1];

    int cyc;
    int busy_until;
    int rr_model;
    int vectors;
    int miscompares;
    logic [NUM_REQ-1:0] hold_rd;

    // Observations taken from the DUT for the directed checks.
    int gnt_ids [$];
    int gnt_cycs [$];
    int last_ack_cyc, obs_err, obs_en, obs_waddr;
    int obs_first_addr, last_rsp_cyc, obs_last_addr, prev_ram_addr;

    task automatic check_val(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Timeline model: a decision made in an idle cycle schedules every output
    // cycle of the resulting transaction.
    task automatic model_eval();
        int k;
        int a;
        int t;
        int start;
        if (rst == 1'b0) begin
            for (int i = cyc + 1; i < TLEN; i++) tl[i] = '0;
            busy_until = cyc;
            rr_model   = NUM_REQ - 1;
            return;
        end
        if (cyc <= busy_until) return;
        if (wr_req) begin
            t = cyc + 1;
            tl[t].wr_ack = 1'b1;
            tl[t].busy   = 1'b1;
            if (int'(wr_addr) > MAX_ADDR) begin
                tl[t].wr_err = 1'b1;
            end else begin
                tl[t].ram_en    = 1'b1;
                tl[t].ram_we    = 1'b1;
                tl[t].ram_addr  = wr_addr;
                tl[t].ram_wdata = wr_data;
                shadow[wr_addr] = wr_data;
            end
            busy_until = t;
        end else if (rd_req != '0) begin
            k = -1;
            for (int d = 1; d <= NUM_REQ; d++) begin
                if (k < 0 && rd_req[(rr_model + d) % NUM_REQ]) k = (rr_model + d) % NUM_REQ;
            end
            rr_model = k;
            start = int'(rd_addr[k*ADDR_W +: ADDR_W]);
            if (start > MAX_ADDR) start = 0;
            tl[cyc + 1].rd_gnt = NUM_REQ'(1) << k;
            for (int j = 0; j < BURST_LEN; j++) begin
                t = cyc + 1 + j;
                a = (start + j) % (MAX_ADDR + 1);
                tl[t].ram_en       = 1'b1;
                tl[t].ram_addr     = ADDR_W'(a);
                tl[t].busy         = 1'b1;
                tl[t+1].rsp_valid  = 1'b1;
                tl[t+1].rsp_id     = ID_W'(k);
                tl[t+1].rsp_data   = shadow[a];
                tl[t+1].rsp_last   = (j == BURST_LEN - 1);
            end
            busy_until = cyc + BURST_LEN;
        end
    endtask

    task automatic check_output();
        exp_t e;
        bit bad;
        e = tl[cyc];
        bad = 1'b0;
        if (ram_en !== e.ram_en) bad = 1'b1;
        if (e.ram_en && (ram_we !== e.ram_we || ram_addr !== e.ram_addr)) bad = 1'b1;
        if (e.ram_en && e.ram_we && ram_wdata !== e.ram_wdata) bad = 1'b1;
        if (wr_ack !== e.wr_ack || wr_err !== e.wr_err) bad = 1'b1;
        if (rd_gnt !== e.rd_gnt || rsp_valid !== e.rsp_valid || busy !== e.busy) bad = 1'b1;
        if (e.rsp_valid && (rsp_id !== e.rsp_id || rsp_data !== e.rsp_data || rsp_last !== e.rsp_last)) bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL cycle %0d outputs: got en=%b we=%b addr=%0d wd=%h ack=%b err=%b gnt=%b rv=%b id=%0d rd=%h last=%b busy=%b, expected en=%b we=%b addr=%0d wd=%h ack=%b err=%b gnt=%b rv=%b id=%0d rd=%h last=%b busy=%b",
                     cyc, ram_en, ram_we, ram_addr, ram_wdata, wr_ack, wr_err, rd_gnt, rsp_valid, rsp_id, rsp_data, rsp_last, busy,
                     e.ram_en, e.ram_we, e.ram_addr, e.ram_wdata, e.wr_ack, e.wr_err, e.rd_gnt, e.rsp_valid, e.rsp_id, e.rsp_data, e.rsp_last, e.busy);
        end
        if (rd_gnt != '0) begin
            for (int k = 0; k < NUM_REQ; k++) if (rd_gnt[k]) gnt_ids.push_back(k);
            gnt_cycs.push_back(cyc);
            obs_first_addr = int'(ram_addr);
        end
        if (wr_ack === 1'b1) begin
            last_ack_cyc = cyc;
            obs_err      = int'(wr_err);
            obs_en       = int'(ram_en);
            obs_waddr    = int'(ram_addr);
        end
        if (rsp_valid === 1'b1 && rsp_last === 1'b1) begin
            last_rsp_cyc  = cyc;
            obs_last_addr = prev_ram_addr;
        end
        prev_ram_addr = int'(ram_addr);
    endtask

    // Requesters drop their request after the grant cycle unless told to hold.
    task automatic auto_release();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (tl[cyc].rd_gnt[k] && !hold_rd[k]) rd_req[k] = 1'b0;
        end
        if (tl[cyc].wr_ack) wr_req = 1'b0;
    endtask

    task automatic step();
        model_eval();
        @(negedge clk);
        cyc++;
        check_output();
        auto_release();
    endtask

    task automatic clear_obs();
        gnt_ids.delete();
        gnt_cycs.delete();
        last_ack_cyc = -1; obs_err = -1; obs_en = -1; obs_waddr = -1;
        obs_first_addr = -1; last_rsp_cyc = -1; obs_last_addr = -1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((cyc <= busy_until + 1 || rd_req != '0 || wr_req) && n < max_cycles) begin
            step();
            n++;
        end
        check_val("idle_wait", int'(n < max_cycles), 1);
    endtask

    task automatic apply_stimulus_random();
        if (!rst) rst = 1'b1;
        else if ($urandom_range(0, 399) == 0) rst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rd_req[k] && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 5) == 0) rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(36, 63));
                else rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 35));
                rd_req[k] = 1'b1;
            end
            hold_rd[k] = ($urandom_range(0, 3) == 0);
        end
        if (!wr_req && $urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 4) == 0) wr_addr = ADDR_W'($urandom_range(36, 63));
            else wr_addr = ADDR_W'($urandom_range(0, 35));
            wr_data = WT_W'($urandom);
            wr_req  = 1'b1;
        end
    endtask

    typedef struct {
        bit              is_wr;
        int              req;
        logic [ADDR_W-1:0] addr;
        logic [WT_W-1:0] data;
        int              exp_err;
        int              exp_first;
        int              exp_last;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 2, 6'd0,  16'h0000, 0, 0,  35};
        vecs[1] = '{0, 0, 6'd30, 16'h0000, 0, 30, 29};
        vecs[2] = '{1, 0, 6'd5,  16'hBEEF, 0, 5,  0};
        vecs[3] = '{1, 0, 6'd40, 16'h1111, 1, 0,  0};
        vecs[4] = '{0, 3, 6'd50, 16'h0000, 0, 0,  35};
        vecs[5] = '{0, 1, 6'd5,  16'h0000, 0, 5,  4};
        vecs[6] = '{1, 0, 6'd35, 16'hCAFE, 0, 35, 0};
        vecs[7] = '{1, 0, 6'd63, 16'h2222, 1, 0,  0};

        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = WT_W'(16'h1000 + i * 37);
            shadow[i]  = WT_W'(16'h1000 + i * 37);
        end
        ram_rdata = '0;
        rst = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = '0; rd_addr = '0; hold_rd = '0;
        cyc = 0; busy_until = -1; rr_model = NUM_REQ - 1;
        vectors = 0; miscompares = 0; prev_ram_addr = 0;
        clear_obs();

        repeat (3) step();
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_ram_en", int'(ram_en), 0);
        rst = 1'b1;
        step();

        // Directed single transactions from the table.
        for (int v = 0; v < 8; v++) begin
            clear_obs();
            if (vecs[v].is_wr) begin
                wr_addr = vecs[v].addr;
                wr_data = vecs[v].data;
                wr_req  = 1'b1;
            end else begin
                rd_addr[vecs[v].req*ADDR_W +: ADDR_W] = vecs[v].addr;
                rd_req[vecs[v].req] = 1'b1;
            end
            wait_idle(200);
            if (vecs[v].is_wr) begin
                check_val("wr_err", obs_err, vecs[v].exp_err);
                check_val("wr_ram_en", obs_en, 1 - vecs[v].exp_err);
                if (vecs[v].exp_err == 0) check_val("wr_addr", obs_waddr, vecs[v].exp_first);
            end else begin
                check_val("gnt_count", gnt_ids.size(), 1);
                if (gnt_ids.size() > 0) check_val("gnt_id", gnt_ids[0], vecs[v].req);
                check_val("first_addr", obs_first_addr, vecs[v].exp_first);
                check_val("last_addr", obs_last_addr, vecs[v].exp_last);
                if (gnt_cycs.size() > 0) check_val("burst_span", last_rsp_cyc - gnt_cycs[0], BURST_LEN);
            end
        end

        // Write and read raised together: write first, then the burst.
        clear_obs();
        wr_addr = 6'd12; wr_data = 16'h5A5A; wr_req = 1'b1;
        rd_addr[1*ADDR_W +: ADDR_W] = 6'd20; rd_req[1] = 1'b1;
        wait_idle(200);
        check_val("prio_gnt_count", gnt_ids.size(), 1);
        if (gnt_ids.size() > 0) begin
            check_val("prio_gnt_id", gnt_ids[0], 1);
            check_val("prio_ack_to_gnt", gnt_cycs[0] - last_ack_cyc, 2);
        end

        // Write arriving mid-burst waits for the burst, then beats the next read.
        clear_obs();
        rd_addr[2*ADDR_W +: ADDR_W] = 6'd10; rd_req[2] = 1'b1;
        for (int n = 0; n < 50 && gnt_ids.size() == 0; n++) step();
        check_val("mid_gnt_seen", gnt_ids.size(), 1);
        repeat (5) step();
        wr_addr = 6'd7; wr_data = 16'h1234; wr_req = 1'b1;
        rd_addr[3*ADDR_W +: ADDR_W] = 6'd3; rd_req[3] = 1'b1;
        wait_idle(300);
        check_val("mid_gnt_count", gnt_ids.size(), 2);
        if (gnt_ids.size() == 2) begin
            check_val("mid_ack_after_burst", last_ack_cyc - gnt_cycs[0], BURST_LEN + 1);
            check_val("mid_ack_to_gnt", gnt_cycs[1] - last_ack_cyc, 2);
            check_val("mid_gnt_id", gnt_ids[1], 3);
        end

        // Reset at the tenth burst word, then round-robin from requester 0.
        clear_obs();
        rd_addr[2*ADDR_W +: ADDR_W] = 6'd0; rd_req[2] = 1'b1;
        for (int n = 0; n < 50 && gnt_ids.size() == 0; n++) step();
        check_val("rst_gnt_seen", gnt_ids.size(), 1);
        repeat (9) step();
        rst = 1'b0;
        step();
        check_val("rst_ram_en", int'(ram_en), 0);
        check_val("rst_rsp_valid", int'(rsp_valid), 0);
        check_val("rst_busy", int'(busy), 0);
        step();
        rst = 1'b1;
        clear_obs();
        rd_addr = {6'd50, 6'd16, 6'd8, 6'd0};
        rd_req  = 4'b1111;
        hold_rd = 4'b1111;
        for (int n = 0; n < 400 && gnt_ids.size() < 5; n++) step();
        check_val("rr_count", gnt_ids.size(), 5);
        if (gnt_ids.size() >= 5) begin
            for (int i = 0; i < 5; i++) check_val("rr_order", gnt_ids[i], i % NUM_REQ);
            for (int i = 0; i < 4; i++) check_val("rr_gap", gnt_cycs[i+1] - gnt_cycs[i], BURST_LEN + 1);
        end
        hold_rd = '0;
        rd_req  = '0;
        wait_idle(200);

        // Random traffic against the timeline model.
        for (int n = 0; n < 1500; n++) begin
            apply_stimulus_random();
            step();
        end
        rst = 1'b1;
        hold_rd = '0;
        wr_req = 1'b0;
        wait_idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/svm_wt_arbiter.md
Name: svm_wt_arbiter

Overview:
- Shares the single-port SVM weight RAM between NUM_REQ PE-group read requesters and a host weight-load write port.
- A read grant is a fixed-length burst of BURST_LEN consecutive addresses, covering one block's 36 weights. Burst addresses wrap at MAX_ADDR.
- Host writes take priority at each arbitration point. Read bursts are shared round-robin among requesters.
- Sits between the weight RAM and the PE-array / sliding-window controllers.

Parameters:
- NUM_REQ, 4, number of read requesters
- ADDR_W, 6, weight RAM address width
- WT_W, 16, weight word width
- MAX_ADDR, 35, last valid RAM address
- BURST_LEN, 36, words per read burst; legal range 1..MAX_ADDR+1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- wr_req  in  1  host write request, level
- wr_addr  in  ADDR_W  host write address
- wr_data  in  WT_W  host write data
- wr_ack  out  1  one-cycle pulse: write accepted
- wr_err  out  1  one-cycle pulse with wr_ack: address > MAX_ADDR, write dropped
- rd_req  in  NUM_REQ  per-requester burst request, level
- rd_addr  in  NUM_REQ*ADDR_W  per-requester burst start address; slice k = bits [k*ADDR_W +: ADDR_W]
- rd_gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  WT_W  RAM write data
- ram_rdata  in  WT_W  RAM read data, valid 1 cycle after a read enable
- rsp_valid  out  1  read data valid
- rsp_id  out  log2(NUM_REQ), min 1  requester index owning rsp_data
- rsp_data  out  WT_W  read word
- rsp_last  out  1  final word of a burst
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = NUM_REQ-1 so requester 0 wins first, burst counter 0, response pipe cleared. A reset mid-burst aborts the burst with no further rsp_valid.
- All outputs are registered.
- States: IDLE, WRITE, BURST.
- IDLE arbitration, sampled each cycle:
  - wr_req=1 -> WRITE.
  - Otherwise, if any rd_req -> grant the first set bit searching from rr_ptr+1 mod NUM_REQ. Set rr_ptr = k, latch start = rd_addr[k], go to BURST.
  - Otherwise stay in IDLE with ram_en=0.
- wr_req and rd_req asserted in the same cycle -> the write wins. Read requests wait; they are not lost.
- WRITE, exactly one cycle:
  - ram_en=1, ram_we=1, ram_addr/ram_wdata = values sampled in IDLE, wr_ack=1. Then return to IDLE.
  - If wr_addr > MAX_ADDR: ram_en=0, wr_ack=1, wr_err=1.
  - Host deasserts wr_req the cycle after wr_ack. A still-high wr_req is a new write.
- BURST:
  - The first cycle also asserts rd_gnt[k] for exactly one cycle.
  - Each of BURST_LEN cycles: ram_en=1, ram_we=0.
  - ram_addr starts at start, or 0 if start > MAX_ADDR, then increments; after MAX_ADDR it wraps to 0.
  - After the BURST_LEN-th cycle, return to IDLE. There is one arbitration cycle between consecutive grants.
  - Writes arriving mid-burst wait; there is no preemption.
- Response path:
  - rsp_valid/rsp_data/rsp_id follow each read enable by exactly 1 cycle.
  - rsp_last is high on the BURST_LEN-th word only.
  - The response may overlap the next IDLE cycle.
- Requester protocol:
  - The requester holds rd_req and rd_addr stable until rd_gnt.
  - rd_req still high in the cycle after rd_gnt is a new request, eligible after the other requesters in round-robin order.
- Burst counter: width ADDR_W+1 bits; no overflow for BURST_LEN = MAX_ADDR+1.
- Throughput: one burst every BURST_LEN+1 cycles while reads are continuously requested.

Test Plan:
- Single read: rd_req[2]=1, rd_addr[2]=0 -> rd_gnt[2] pulse; ram_addr 0..35 over 36 cycles; 36 rsp_valid with rsp_id=2, lagging ram_addr by 1; rsp_last on address 35.
- Wrap: rd_addr[0]=30 -> ram_addr 30..35, then 0..29; rsp_last on address 29.
- Round-robin: all rd_req held high -> grant order 0,1,2,3,0, with one idle cycle between bursts; no requester is granted twice before the others.
- Write priority: wr_req and rd_req[1] rise together -> WRITE first (wr_ack, ram_we=1), then burst for requester 1. wr_req raised mid-burst -> serviced after rsp_last of the current burst, before the next read grant.
- Bad addresses: wr_addr=40 -> wr_ack=1, wr_err=1, ram_en=0. rd_addr=50 -> burst starts at 0.
- Reset: rst=0 at burst word 10 -> next cycle ram_en, rsp_valid, busy = 0. After release, requester 0 wins first.
